fetch_sequencer: RTL

PC/nPC register pair and IF/ID pipeline register for the SPARC-style pipeline. It consumes the control-transfer decision: nPC_sel, the IF/ID flush, and the annul request for a branch with a=1. It advances PC/nPC with delayed-branch semantics and loads or squashes the fetched instruction into IF/ID. It also records a deferred delay-slot annul across stalls.

---
 rtl/fetch_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC/nPC pair with SPARC delayed-branch semantics and the
// IF/ID pipeline register. Consumes the control-transfer decision (nPC_sel,
// IF/ID flush, delay-slot annul) and remembers an annul that arrived during
// a stall so the delay slot is squashed when the pipeline moves again.
//
// Ports:
//   clk, R          rising-edge clock, asynchronous active-low reset
//   LE              pipeline load enable (0 = stall)
//   nPC_sel         00 seq, 01 TAG, 10 ALU_out, 11 reserved (seq)
//   TAG, ALU_out    branch/call and jmpl targets
//   IF_ID_R         flush IF/ID
//   annul_req       annul the delay slot being fetched this cycle
//   instr_in        instruction memory data at PC
//   PC, nPC         current / next fetch address
//   IF_ID_instr/PC  IF/ID instruction and its address
//   IF_ID_valid     IF/ID holds a real instruction
//   annul_pending   deferred annul armed (SQUASH state)
//   misalign        last accepted target had nonzero bits [1:0]
module fetch_sequencer #(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]      NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              R,
  input  logic              LE,
  input  logic [1:0]        nPC_sel,
  input  logic [ADDR_W-1:0] TAG,
  input  logic [ADDR_W-1:0] ALU_out,
  input  logic              IF_ID_R,
  input  logic              annul_req,
  input  logic [31:0]       instr_in,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] nPC,
  output logic [31:0]       IF_ID_instr,
  output logic [ADDR_W-1:0] IF_ID_PC,
  output logic              IF_ID_valid,
  output logic              annul_pending,
  output logic              misalign
);

  typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_d, npc_d, ifpc_d, sel_tgt, next_npc;
  logic [31:0]       instr_d;
  logic              valid_d, pend_d, mis_d, redirect, advance;

  // Target mux; targets are word-aligned by dropping bits [1:0].
  always_comb begin
    sel_tgt  = (nPC_sel == 2'b01) ? TAG : ALU_out;
    redirect = (nPC_sel == 2'b01) || (nPC_sel == 2'b10);
    next_npc = redirect ? {sel_tgt[ADDR_W-1:2], 2'b00} : nPC + ADDR_W'(4);
  end

  always_comb begin
    state_d = state;
    pc_d    = PC;
    npc_d   = nPC;
    instr_d = IF_ID_instr;
    ifpc_d  = IF_ID_PC;
    valid_d = IF_ID_valid;
    pend_d  = annul_pending;
    mis_d   = misalign;
    advance = (state != BOOT) && LE;

    case (state)
      BOOT:    state_d = RUN;
      RUN:     if (!LE && annul_req) begin
                 pend_d  = 1'b1;
                 state_d = SQUASH;
               end
      // Either the pipeline moving or a flush consumes the deferred annul.
      SQUASH:  if (LE || IF_ID_R) begin
                 pend_d  = 1'b0;
                 state_d = RUN;
               end
      default: state_d = RUN;
    endcase

    if (advance) begin
      pc_d    = nPC;
      npc_d   = next_npc;
      ifpc_d  = PC;
      instr_d = instr_in;
      valid_d = 1'b1;
      if (redirect) mis_d = |sel_tgt[1:0];
      // Annul now, or annul deferred from a stall: the fetched slot is dropped.
      if (state == SQUASH || annul_req) begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end
    end

    // Flush works regardless of LE; BOOT ignores every input.
    if (state != BOOT && IF_ID_R) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state         <= BOOT;
      PC            <= RESET_PC;
      nPC           <= RESET_PC + ADDR_W'(4);
      IF_ID_instr   <= NOP_WORD;
      IF_ID_PC      <= '0;
      IF_ID_valid   <= 1'b0;
      annul_pending <= 1'b0;
      misalign      <= 1'b0;
    end else begin
      state         <= state_d;
      PC            <= pc_d;
      nPC           <= npc_d;
      IF_ID_instr   <= instr_d;
      IF_ID_PC      <= ifpc_d;
      IF_ID_valid   <= valid_d;
      annul_pending <= pend_d;
      misalign      <= mis_d;
    end
  end

endmodule
